// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: owns the word-indexed PC, issues instruction-memory
// requests, and loads the IF/ID register with stall (skid/HOLD) and branch-flush handling.
module pc_fetch_stage #(
    parameter int                  PC_WIDTH    = 64,
    parameter int                  INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_stall,
    input  logic                   i_branch_taken,
    input  logic [PC_WIDTH-1:0]    i_branch_target,
    output logic                   o_imem_req,
    output logic [PC_WIDTH-1:0]    o_imem_addr,
    input  logic                   i_imem_ready,
    input  logic [INSTR_WIDTH-1:0] i_imem_data,
    output logic                   o_ifid_valid,
    output logic [PC_WIDTH-1:0]    o_ifid_pc,
    output logic [INSTR_WIDTH-1:0] o_ifid_instr
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [PC_WIDTH-1:0]    r_pc;
    logic [PC_WIDTH-1:0]    r_skid_pc;
    logic [INSTR_WIDTH-1:0] r_skid_instr;
    logic                   r_squash;
    logic [PC_WIDTH-1:0]    r_redirect;
    logic                   r_ifid_valid;
    logic [PC_WIDTH-1:0]    r_ifid_pc;
    logic [INSTR_WIDTH-1:0] r_ifid_instr;
    logic                   w_imem_req;
    logic                   w_fetch_done;
    logic [PC_WIDTH-1:0]    w_pc_next_seq;

    assign w_fetch_done  = (r_state == ST_FETCH) && i_imem_ready;
    assign w_pc_next_seq = r_pc + PC_WIDTH'(1);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: w_next_state = ST_FETCH;
            ST_FETCH: begin
                if (!i_branch_taken && w_fetch_done && !r_squash && i_stall) begin
                    w_next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (i_branch_taken || !i_stall) begin
                    w_next_state = ST_FETCH;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_imem_req = (r_state == ST_FETCH);
    end

    // A branch during an outstanding fetch cannot move the address, so the
    // target is parked in r_redirect and the in-flight word is squashed on return.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc         <= RESET_PC;
            r_skid_pc    <= '0;
            r_skid_instr <= '0;
            r_squash     <= 1'b0;
            r_redirect   <= '0;
            r_ifid_valid <= 1'b0;
            r_ifid_pc    <= '0;
            r_ifid_instr <= '0;
        end else if (i_branch_taken) begin
            r_ifid_valid <= 1'b0;
            if ((r_state == ST_FETCH) && !i_imem_ready) begin
                r_squash   <= 1'b1;
                r_redirect <= i_branch_target;
            end else begin
                r_pc     <= i_branch_target;
                r_squash <= 1'b0;
            end
        end else if (w_fetch_done && r_squash) begin
            r_pc     <= r_redirect;
            r_squash <= 1'b0;
        end else if (w_fetch_done && !i_stall) begin
            r_ifid_valid <= 1'b1;
            r_ifid_pc    <= r_pc;
            r_ifid_instr <= i_imem_data;
            r_pc         <= w_pc_next_seq;
        end else if (w_fetch_done) begin
            r_skid_pc    <= r_pc;
            r_skid_instr <= i_imem_data;
            r_pc         <= w_pc_next_seq;
        end else if ((r_state == ST_HOLD) && !i_stall) begin
            r_ifid_valid <= 1'b1;
            r_ifid_pc    <= r_skid_pc;
            r_ifid_instr <= r_skid_instr;
        end else if ((r_state == ST_FETCH) && !i_stall) begin
            r_ifid_valid <= 1'b0;
        end
    end

    assign o_imem_req   = w_imem_req;
    assign o_imem_addr  = r_pc;
    assign o_ifid_valid = r_ifid_valid;
    assign o_ifid_pc    = r_ifid_pc;
    assign o_ifid_instr = r_ifid_instr;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Scoreboard bench for pc_fetch_stage: expected IF/ID hand-offs and completed
// fetch addresses are queued by the stimulus and popped by a negedge monitor.
module tb_pc_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branchTaken;
    logic [63:0] branchTarget;
    logic        imemReady;
    logic        imemReq;
    logic [63:0] imemAddr;
    logic [31:0] imemData;
    logic        ifidValid;
    logic [63:0] ifidPc;
    logic [31:0] ifidInstr;

    logic        imemReq2;
    logic [63:0] imemAddr2;
    logic [31:0] imemData2;
    logic        ifidValid2;
    logic [63:0] ifidPc2;
    logic [31:0] ifidInstr2;

    int checks   = 0;
    int failures = 0;
    bit monitorOn = 1'b0;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ifidExp_t;

    ifidExp_t    ifidQ[$];
    logic [63:0] fetchQ[$];
    ifidExp_t    ifidItem;
    logic [63:0] fetchItem;

    always #5 clk = ~clk;

    assign imemData  = 32'hA000_0000 + imemAddr[31:0];
    assign imemData2 = 32'hA000_0000 + imemAddr2[31:0];

    pc_fetch_stage #(
        .PC_WIDTH   (64),
        .INSTR_WIDTH(32),
        .RESET_PC   (64'h0)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_stall        (stall),
        .i_branch_taken (branchTaken),
        .i_branch_target(branchTarget),
        .o_imem_req     (imemReq),
        .o_imem_addr    (imemAddr),
        .i_imem_ready   (imemReady),
        .i_imem_data    (imemData),
        .o_ifid_valid   (ifidValid),
        .o_ifid_pc      (ifidPc),
        .o_ifid_instr   (ifidInstr)
    );

    // Second instance exercises the PC wrap from the all-ones reset address.
    pc_fetch_stage #(
        .PC_WIDTH   (64),
        .INSTR_WIDTH(32),
        .RESET_PC   (64'hFFFF_FFFF_FFFF_FFFF)
    ) dutWrap (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_stall        (1'b0),
        .i_branch_taken (1'b0),
        .i_branch_target(64'h0),
        .o_imem_req     (imemReq2),
        .o_imem_addr    (imemAddr2),
        .i_imem_ready   (1'b1),
        .i_imem_data    (imemData2),
        .o_ifid_valid   (ifidValid2),
        .o_ifid_pc      (ifidPc2),
        .o_ifid_instr   (ifidInstr2)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic st, input logic br,
                                 input logic [63:0] tgt, input logic rdy);
        reset        = rst;
        stall        = st;
        branchTaken  = br;
        branchTarget = tgt;
        imemReady    = rdy;
        @(posedge clk);
        #1;
    endtask

    function automatic void expectIfid(input logic [63:0] pc);
        logic [31:0] low;
        low = pc[31:0];
        ifidQ.push_back('{pc: pc, instr: 32'hA000_0000 + low});
    endfunction

    function automatic void expectFetch(input logic [63:0] addr);
        fetchQ.push_back(addr);
    endfunction

    // ID consumes IF/ID whenever it is valid and not stalled; a completed
    // fetch is any cycle with a request and ready both high.
    always @(negedge clk) begin
        if (monitorOn) begin
            if (ifidValid && !stall) begin
                if (ifidQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL ifid_unexpected actual_pc=%h required=none", ifidPc);
                end else begin
                    ifidItem = ifidQ.pop_front();
                    checkOutput("ifid_pc", ifidPc, ifidItem.pc);
                    checkOutput("ifid_instr", 64'(ifidInstr), 64'(ifidItem.instr));
                end
            end
            if (imemReq && imemReady) begin
                if (fetchQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL fetch_unexpected actual_addr=%h required=none", imemAddr);
                end else begin
                    fetchItem = fetchQ.pop_front();
                    checkOutput("fetch_addr", imemAddr, fetchItem);
                end
            end
        end
    end

    initial begin
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b1);
        checkOutput("rst_req", 64'(imemReq), 64'h0);
        checkOutput("rst_addr", imemAddr, 64'h0);
        checkOutput("rst_valid", 64'(ifidValid), 64'h0);
        checkOutput("rst_ifid_pc", ifidPc, 64'h0);
        checkOutput("rst_ifid_instr", 64'(ifidInstr), 64'h0);
        checkOutput("wrap_rst_addr", imemAddr2, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("wrap_rst_req", 64'(imemReq2), 64'h0);
        monitorOn = 1'b1;

        // Zero-wait streaming from reset.
        for (int a = 0; a < 3; a++) begin
            expectFetch(64'(a));
            expectIfid(64'(a));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        checkOutput("first_req", 64'(imemReq), 64'h1);
        checkOutput("first_addr", imemAddr, 64'h0);
        checkOutput("wrap_first_addr", imemAddr2, 64'hFFFF_FFFF_FFFF_FFFF);
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        checkOutput("wrap_second_addr", imemAddr2, 64'h0);
        checkOutput("wrap_ifid_pc", ifidPc2, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("wrap_ifid_instr", 64'(ifidInstr2), 64'h9FFF_FFFF);
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        checkOutput("wrap_ifid_pc_next", ifidPc2, 64'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);

        // Two wait states on the fetch of address 3.
        expectFetch(64'd3); expectFetch(64'd4);
        expectIfid(64'd3);  expectIfid(64'd4);
        checkOutput("wait_addr_0", imemAddr, 64'd3);
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        checkOutput("wait_addr_1", imemAddr, 64'd3);
        checkOutput("wait_bubble_1", 64'(ifidValid), 64'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        checkOutput("wait_addr_2", imemAddr, 64'd3);
        checkOutput("wait_bubble_2", 64'(ifidValid), 64'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        checkOutput("wait_addr_after", imemAddr, 64'd4);
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);

        // Stall while word 5 returns: it goes to the skid and is delivered on release.
        for (int a = 5; a < 9; a++) expectFetch(64'(a));
        for (int a = 5; a < 8; a++) expectIfid(64'(a));
        applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b1);
        checkOutput("stall_req_low_1", 64'(imemReq), 64'h0);
        checkOutput("stall_frozen_pc_1", ifidPc, 64'd4);
        applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b1);
        checkOutput("stall_req_low_2", 64'(imemReq), 64'h0);
        checkOutput("stall_frozen_pc_2", ifidPc, 64'd4);
        applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        checkOutput("stall_release_pc", ifidPc, 64'd5);
        checkOutput("stall_resume_req", 64'(imemReq), 64'h1);
        checkOutput("stall_resume_addr", imemAddr, 64'd6);
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);

        // Branch to 0x100 while the fetch of 9 is still outstanding.
        expectFetch(64'd9); expectFetch(64'h100);
        expectIfid(64'd8);  expectIfid(64'h100);
        applyStimulus(1'b0, 1'b0, 1'b1, 64'h100, 1'b0);
        checkOutput("squash_addr_hold_1", imemAddr, 64'd9);
        checkOutput("squash_valid_1", 64'(ifidValid), 64'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        checkOutput("squash_addr_hold_2", imemAddr, 64'd9);
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        checkOutput("squash_redirect_addr", imemAddr, 64'h100);
        checkOutput("squash_valid_2", 64'(ifidValid), 64'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);

        // Branch to 0x40 while stalled in HOLD: skid word 0x102 must be dropped.
        expectFetch(64'h101); expectFetch(64'h102);
        expectFetch(64'h40);  expectFetch(64'h41);
        expectIfid(64'h40);   expectIfid(64'h41);
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b1);
        checkOutput("hold_req_low", 64'(imemReq), 64'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 64'h40, 1'b1);
        checkOutput("hold_branch_valid", 64'(ifidValid), 64'h0);
        checkOutput("hold_branch_addr", imemAddr, 64'h40);
        checkOutput("hold_branch_req", 64'(imemReq), 64'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);

        // Reset asserted during a wait, then a late READY while in IDLE.
        for (int a = 0; a < 4; a++) expectFetch(64'(a));
        for (int a = 0; a < 3; a++) expectIfid(64'(a));
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
        checkOutput("midrst_req", 64'(imemReq), 64'h0);
        checkOutput("midrst_addr", imemAddr, 64'h0);
        checkOutput("midrst_valid", 64'(ifidValid), 64'h0);
        checkOutput("midrst_ifid_pc", ifidPc, 64'h0);
        checkOutput("midrst_ifid_instr", 64'(ifidInstr), 64'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        checkOutput("midrst_first_req", 64'(imemReq), 64'h1);
        checkOutput("midrst_first_addr", imemAddr, 64'h0);
        for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);

        // Freeze everything so nothing more is consumed or fetched.
        applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
        monitorOn = 1'b0;
        checkOutput("ifid_queue_drained", 64'(ifidQ.size()), 64'h0);
        checkOutput("fetch_queue_drained", 64'(fetchQ.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_fetch_stage.md
# pc_fetch_stage

Instruction-fetch stage for the segmented ARMv8 core. It owns the program counter, drives the word-addressed instruction-memory request interface, and loads the IF/ID pipeline register. The PC advances by one word per fetch; the PC is a word index, not a byte address. The block also applies pipeline stall (hold) and branch redirect (flush) coming from later stages.

## Interface
- PC_WIDTH, 64: program counter and address width.
- INSTR_WIDTH, 32: instruction word width.
- RESET_PC, 0: first fetch address after reset.

- CLK  in  1  single clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- STALL  in  1  hold request from hazard unit; IF/ID must not change.
- BRANCH_TAKEN  in  1  one-cycle redirect pulse from EX.
- BRANCH_TARGET  in  PC_WIDTH  redirect word address, sampled when BRANCH_TAKEN=1.
- IMEM_REQ  out  1  fetch request, registered.
- IMEM_ADDR  out  PC_WIDTH  fetch word address (PC register).
- IMEM_READY  in  1  memory returns IMEM_DATA for IMEM_ADDR this cycle.
- IMEM_DATA  in  INSTR_WIDTH  instruction word.
- IFID_VALID  out  1  IF/ID holds a live instruction.
- IFID_PC  out  PC_WIDTH  word address of IFID_INSTR.
- IFID_INSTR  out  INSTR_WIDTH  fetched instruction.

## Operation
- State machine:
  - IDLE: entered on reset; IMEM_REQ=0; always moves to FETCH next cycle.
  - FETCH: IMEM_REQ=1, IMEM_ADDR=PC.
  - HOLD: IMEM_REQ=0; the skid register holds one fetched word.
- Internal state: PC, skid {PC, instr}, squash flag, redirect register.
- Reset values: PC=RESET_PC; IMEM_REQ=0; IMEM_ADDR=RESET_PC; IFID_VALID=0, IFID_PC=0, IFID_INSTR=0; squash=0; state IDLE.
- Per-cycle rules (first match wins):
  1. RESET.
  2. BRANCH_TAKEN. IFID_VALID<=0 and the skid is discarded, regardless of STALL.
     - FETCH with READY=0: squash<=1, redirect<=BRANCH_TARGET; IMEM_ADDR stays unchanged.
     - FETCH with READY=1: the returned word is dropped; PC<=BRANCH_TARGET.
     - IDLE or HOLD: PC<=BRANCH_TARGET; go to FETCH.
     - A new branch while squash=1 overwrites redirect.
  3. FETCH, READY, squash=1: the word is dropped; PC<=redirect; squash<=0. IF/ID is unchanged.
  4. FETCH, READY, STALL=0: IF/ID<={PC, IMEM_DATA}; IFID_VALID<=1; PC<=PC+1.
  5. FETCH, READY, STALL=1: skid<={PC, IMEM_DATA}; PC<=PC+1; go to HOLD. IF/ID holds.
  6. HOLD, STALL=0: IF/ID<=skid; IFID_VALID<=1; go to FETCH.
  7. FETCH, READY=0: if STALL=0, IFID_VALID<=0 (bubble); if STALL=1, IF/ID holds.
- Memory rule: while IMEM_REQ=1 and IMEM_READY=0, IMEM_ADDR is stable. A request is never withdrawn. STALL does not drop an outstanding request.
- PC+1 wraps modulo 2^PC_WIDTH. No instruction is ever lost, duplicated, or reordered across stalls.

## Timing
- Zero-wait memory (READY=1 whenever REQ=1):
  - Reset released at edge E0: IDLE during the following cycle.
  - REQ=1 with ADDR=RESET_PC after E1.
  - IFID_VALID=1 with IFID_PC=RESET_PC after E2.
  - Throughput: one instruction per cycle.
- Each wait cycle adds one bubble (IFID_VALID=0 when not stalled).
- Branch to first redirected fetch request: 1 cycle if the request has already completed. Otherwise it is the completion cycle of the outstanding request plus 1.
- Stall release from HOLD: IF/ID loads at the next edge, and REQ resumes the cycle after that.
- RESET mid-request, mid-HOLD, or with squash pending: everything returns to reset values. Late READY pulses are ignored while in IDLE.

## Test plan
- Reset, RESET_PC=0, READY tied 1, IMEM_DATA=0xA000_0000+ADDR. Required: IFID_PC runs 0,1,2,3 on consecutive cycles starting 2 cycles after reset release, and IFID_INSTR matches.
- READY delayed 2 cycles on the fetch of address 3. Required: IMEM_ADDR holds 3 for 3 cycles, 2 bubbles appear, then IFID_PC=3 followed by 4.
- STALL high 3 cycles while READY=1 at PC=5. Required: IF/ID frozen; word 5 is captured in the skid; REQ low 2 cycles. On release the sequence continues 5,6,7 with no duplicate or gap.
- BRANCH_TAKEN with target 0x100 while fetch 9 waits, READY arriving 2 cycles later. Required: word 9 never reaches IF/ID, the next REQ address is 0x100, and IFID_PC=0x100 follows.
- BRANCH_TAKEN with target 0x40 together with STALL=1 in HOLD. Required: IFID_VALID=0 next cycle, skid dropped, next fetch address 0x40.
- RESET_PC=0xFFFF_FFFF_FFFF_FFFF. Required: fetch address sequence is 0xFFFF_FFFF_FFFF_FFFF, then 0. Separately, assert RESET during a wait. Required: all outputs return to reset values, and the first fetch after reset is RESET_PC.
